// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcodes and the datapath select/ALU/immediate encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_dec.sv
// Combinational funct3/funct7 to ALU operation decode used in the execute states.
module alu_dec
    import mc_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        case (funct3)
            3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V style Moore controller with a memory wait timeout and
// an absorbing FAULT state.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       fault
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] wait_reg;
    logic          timed_out;
    logic          waiting;
    logic [2:0]    funct_alu;

    alu_dec u_alu_dec (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_control(funct_alu)
    );

    assign waiting   = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                       (state_reg == S_MEMWRITE);
    // mem_ready wins over the timeout because timed_out requires it low.
    assign timed_out = (MEM_TIMEOUT > 0) && !mem_ready && (wait_reg == WAIT_LIMIT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
                        else if (timed_out) state_next = S_FAULT;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = (funct3 == 3'b000) ? S_BEQ : S_FAULT;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FAULT;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
                        else if (timed_out) state_next = S_FAULT;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
                        else if (timed_out) state_next = S_FAULT;
            S_EXECUTER, S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB, S_BEQ:         state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                wait_reg <= '0;
            end else if (waiting && !mem_ready && wait_reg != '1) begin
                wait_reg <= wait_reg + 1'b1;
            end
        end
    end

    // Reset holds state at FETCH, so only the enables need gating by reset_n.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        fault       = 1'b0;
        imm_src     = imm_decode(op);
        retire      = reset_n && (state_next == S_FETCH) &&
                      (state_reg != S_FETCH) && (state_reg != S_FAULT);
        case (state_reg)
            S_FETCH: begin
                mem_req    = reset_n;
                ir_write   = reset_n && mem_ready;
                pc_write   = reset_n && mem_ready;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a   = SRCA_RS1;
                alu_control = funct_alu;
            end
            S_EXECUTEI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = funct_alu;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_control = ALU_SUB;
                pc_write    = zero;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: consecutive cycles of mem_ready low tolerated in a memory state; 0 disables the timeout.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  instruction opcode, from the instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 mem_req  output  1  memory access request.
REQ-010 mem_write  output  1  memory access is a store.
REQ-011 adr_src  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-012 ir_write  output  1  load instruction register and oldPC.
REQ-013 pc_write  output  1  load PC.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 result_src  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-016 alu_src_a  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-017 alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-018 alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-019 imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-020 retire  output  1  one-cycle pulse when an instruction completes.
REQ-021 fault  output  1  sticky fault indicator.

Function
REQ-022 Moore FSM, states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, FAULT; outputs are decoded from state, plus mem_ready/zero where stated below; unlisted outputs are 0.
REQ-023 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - Only in the cycle mem_ready=1: ir_write=1, pc_write=1, and next state is DECODE.
  - Otherwise the FSM holds in FETCH.
REQ-024 DECODE: alu_src_a=01, alu_src_b=01, add (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 with funct3=000 -> BEQ.
  - 1101111 -> JAL.
  - Anything else -> FAULT.
REQ-025 MEMADR: alu_src_a=10, alu_src_b=01, add. Next state is MEMREAD if op[5]=0, else MEMWRITE.
REQ-026 MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until mem_ready=1, then -> MEMWB.
REQ-027 MEMWB: result_src=01, reg_write=1, then -> FETCH.
REQ-028 MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready=1, then -> FETCH.
REQ-029 EXECUTER: alu_src_a=10, alu_src_b=00, ALU op from funct. Next state ALUWB.
REQ-030 EXECUTEI: alu_src_a=10, alu_src_b=01, ALU op from funct. Next state ALUWB.
REQ-031 ALUWB: result_src=00, reg_write=1, then -> FETCH.
REQ-032 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, then -> FETCH.
REQ-033 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then -> ALUWB.
REQ-034 ALU op from funct, by funct3:
  - 000: sub if op[5]&funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other value: add.
REQ-035 imm_src is decoded combinationally from op in every state:
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; otherwise 00.
REQ-036 retire=1 in the cycle where the next state is FETCH, taken from any state other than FETCH and FAULT.
REQ-037 Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in those states while mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0, next state is FAULT.
  - mem_ready=1 in that same cycle takes priority over the timeout.
REQ-038 The counter width is $clog2(MEM_TIMEOUT+1) and it saturates; it cannot wrap.
REQ-039 FAULT: fault=1 and all enables are 0. FAULT is absorbing; only reset exits it.

Reset
REQ-040 reset_n low asynchronously forces state FETCH, clears the wait counter, and deasserts fault.
REQ-041 While reset_n is low, outputs take their FETCH values except ir_write=0, pc_write=0, retire=0 and mem_req=0.
REQ-042 Reset asserted mid-access abandons the access; after release, the first active edge evaluates FETCH.

Structure
REQ-043 Package mc_pkg holds:
  - the state enum;
  - the opcode constants;
  - the alu_control, result_src, alu_src_a, alu_src_b and imm_src encodings.
REQ-044 The funct-to-ALU-op decode is a combinational sub-module alu_dec; all state and the counter stay in mc_controller.

Verification
REQ-045 Bench covers lw (op 0000011), mem_ready=1 always -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 in cycle 5; retire in cycle 5.
REQ-046 Bench covers sw, mem_ready low for 3 cycles in MEMWRITE -> mem_write and mem_req held for 4 cycles, no fault, then FETCH.
REQ-047 Bench covers beq twice -> pc_write=1 in BEQ when zero=1 and pc_write=0 when zero=0; alu_control=001 in both.
REQ-048 Bench covers R-type with funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER; with funct7b5=0 -> 000.
REQ-049 Bench covers MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> FAULT entered after 4 FETCH cycles; fault stays 1 until reset_n is pulsed low.
REQ-050 Bench covers op 1111111 -> DECODE then FAULT; reset_n asserted asynchronously mid-MEMREAD -> mem_req drops immediately and the FSM restarts in FETCH.
